arb_mux: RTL
============

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter N, default 32, data width per channel in bits (N >= 1).
REQ-002 Parameter M, default 4, number of input channels (M >= 1).
REQ-003 Parameter MODE, default 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins); other values are illegal.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  M  per-channel request; bit i qualifies channel i.
REQ-007 in_data  input  M*N  channel i data occupies bits [i*N +: N].
REQ-008 in_ready  output  M  one-hot-or-zero grant; bit i high means channel i's beat is consumed this cycle.
REQ-009 out_valid  output  1  output register holds a valid beat.
REQ-010 out_data  output  N  registered data of the granted channel.
REQ-011 out_sel  output  S  index of the channel that supplied out_data, where S = max(1, ceil(log2 M)).
REQ-012 out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high.

Function
REQ-013 The block SHALL have one output register stage; a beat accepted in cycle t SHALL appear on out_valid/out_data/out_sel in cycle t+1.
REQ-014 load_en SHALL equal (!out_valid) | out_ready; arbitration and acceptance happen only when load_en is high.
REQ-015 When load_en is high and any in_valid bit is set, exactly one in_ready bit SHALL be high, chosen per MODE; otherwise in_ready SHALL be all zero.
REQ-016 in_ready SHALL be combinational from in_valid, out_valid, out_ready and the priority pointer, and SHALL NOT depend on in_data.
REQ-017 MODE 0: the search SHALL start at pointer P and proceed upward with wrap-around modulo M; after a grant to channel g, P SHALL become (g+1) mod M.
REQ-018 MODE 0: P SHALL be unchanged in cycles without a grant.
REQ-019 MODE 1: the lowest-index valid channel SHALL win; P SHALL remain 0.
REQ-020 On a grant, the output register SHALL load in_data of channel g, out_sel = g, out_valid = 1.
REQ-021 On a pop (out_valid & out_ready) without a new grant, out_valid SHALL go 0; out_data and out_sel SHALL hold their last values.
REQ-022 Simultaneous pop and grant in one cycle SHALL replace the beat with no bubble, sustaining one beat per cycle.
REQ-023 While out_valid & !out_ready, out_data and out_sel SHALL be held stable, and in_ready SHALL be all zero.
REQ-024 M = 1: the channel SHALL be granted whenever in_valid[0] & load_en, and out_sel SHALL be constant 0.
REQ-025 An in_valid bit that drops without a grant SHALL NOT be recorded; the block keeps no per-channel state beyond P.

Reset
REQ-026 While rst_n is low: out_valid = 0, out_data = 0, out_sel = 0, P = 0, and in_ready = 0, independent of clk.
REQ-027 Reset asserted mid-stall SHALL discard the held beat; no beat SHALL be issued on the first edge after rst_n rises unless a grant occurs on that edge.

Structure
REQ-028 The MODE encodings (ARB_MODE_RR = 0, ARB_MODE_FIXED = 1) SHALL live in the shared package/header with the other datapath constants, and are used by all instantiating units.
REQ-029 The arbitration logic (request vector, pointer and MODE in; one-hot grant and encoded index out) SHALL be a sub-module named rr_arbiter. The output register and pointer update SHALL stay in arb_mux.
REQ-030 No latches; the data path SHALL be an indexed select on the encoded grant index, not a priority chain of 2:1 selects.

Verification
REQ-031 Reset: with rst_n = 0 and in_valid = 4'b1111, all outputs are 0 and in_ready = 0. After release with out_ready = 1, channel 0 is granted first.
REQ-032 Round-robin, M = 4, N = 32, in_valid = 4'b1111 held, out_ready = 1, data[i] = 32'hA0+i: out_sel sequence is 0,1,2,3,0 on consecutive cycles with matching out_data and no bubbles.
REQ-033 Stall: a beat is held with out_ready = 0 for 3 cycles. out_data and out_sel stay constant, in_ready = 0, and P is unchanged. On release the next grant follows REQ-017.
REQ-034 Wrap: with P = 3 and in_valid = 4'b0101, channel 0 is granted and P becomes 1. A following in_valid = 4'b0101 grants channel 2.
REQ-035 Fixed priority: with MODE = 1 and in_valid = 4'b1110 held, channel 1 wins every cycle. Channels 2 and 3 never receive in_ready.
REQ-036 Async reset mid-stall: rst_n is pulsed low between clock edges while out_valid = 1. out_valid drops immediately, with no beat lost or duplicated beyond the discarded one.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared constants for the arbitrated output multiplexer and its arbiter.
package arb_mux_pkg;

  // Arbitration mode encodings.
  localparam int ARB_MODE_RR    = 0;
  localparam int ARB_MODE_FIXED = 1;

  // Default datapath geometry.
  localparam int ARB_DEF_N = 32;
  localparam int ARB_DEF_M = 4;

  // Width of a channel index: at least one bit even for a single channel.
  function automatic int sel_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pure combinational arbiter: picks one requester, searching upward from
// ptr_i with wrap-around (round-robin) or from index 0 (fixed priority).
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int M    = ARB_DEF_M,
  parameter int MODE = ARB_MODE_RR,
  parameter int S    = sel_width(M)
) (
  input  logic [M-1:0] req_i,
  input  logic [S-1:0] ptr_i,
  output logic [M-1:0] gnt_o,
  output logic [S-1:0] idx_o,
  output logic         any_o
);

  int start;
  int cand;

  // First requester at or after the start position wins; later ones are masked.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    start = (MODE == ARB_MODE_FIXED) ? 0 : int'(ptr_i);
    for (int k = 0; k < M; k++) begin
      cand = (start + k) % M;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = S'(cand);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// M-channel arbitrated multiplexer with a single registered output stage.
// A beat granted in cycle t is presented on out_* in cycle t+1; a pop and
// a new grant in the same cycle sustain one beat per cycle.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int N    = ARB_DEF_N,
  parameter int M    = ARB_DEF_M,
  parameter int MODE = ARB_MODE_RR,
  localparam int S   = sel_width(M)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M-1:0]   in_valid,
  input  logic [M*N-1:0] in_data,
  output logic [M-1:0]   in_ready,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic [S-1:0]   out_sel,
  input  logic           out_ready
);

  logic [N-1:0] ch_data [M];
  logic         load_en;
  logic [M-1:0] req;
  logic [M-1:0] gnt;
  logic [S-1:0] gidx;
  logic         grant;

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q,  out_data_d;
  logic [S-1:0] out_sel_q,   out_sel_d;
  logic [S-1:0] ptr_q,       ptr_d;

  // Unpack the flat data bus so the output mux is a plain indexed select.
  for (genvar gi = 0; gi < M; gi++) begin : g_unpack
    assign ch_data[gi] = in_data[gi*N +: N];
  end

  // Requests are only visible when the output register can take a beat,
  // and never while reset is asserted.
  assign load_en = !out_valid_q || out_ready;
  assign req     = (rst_n && load_en) ? in_valid : '0;

  rr_arbiter #(
    .M    (M),
    .MODE (MODE),
    .S    (S)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (grant)
  );

  assign in_ready = gnt;

  // Pointer moves just past the granted channel; fixed priority keeps it at 0.
  always_comb begin
    ptr_d = ptr_q;
    if (MODE != ARB_MODE_FIXED && grant) begin
      ptr_d = (gidx == S'(M - 1)) ? '0 : gidx + S'(1);
    end
  end

  // Output register: load on grant, empty on a pop without replacement.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[gidx];
      out_sel_d   = gidx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any held beat immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
